// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with one-byte holding register and valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial_out,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4
  } state_e;
  state_e        state_q, state_d;
  logic [7:0]    hold_q, hold_d, shift_q, shift_d;
  logic          hold_valid_q, hold_valid_d, line_q, line_d, done_q, done_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          bit_end, load, accept;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  always_comb begin
    bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
    accept  = tx_valid && !hold_valid_q;
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (hold_valid_q) begin
        load    = 1'b1;
        state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        done_d  = 1'b1;
        load    = hold_valid_q;
        state_d = hold_valid_q ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d = hold_q;
      bit_d   = 3'd0;
    end
    hold_valid_d = load ? 1'b0 : accept ? 1'b1 : hold_valid_q;
    hold_d       = accept ? tx_data : hold_q;
    // Counter restarts at every bit boundary, including STOP->START hand-off.
    baud_d = (state_d != state_q || bit_end || state_q == IDLE) ? '0 : baud_q + BW'(1);
`ifdef UART_TX_PARITY_EN
    par_d  = load ? ^hold_q : par_q;
    line_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
             (state_d == PARITY) ? par_d : 1'b1;
`else
    line_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      line_q       <= 1'b1;
      done_q       <= 1'b0;
      bit_q        <= '0;
      baud_q       <= '0;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      line_q       <= line_d;
      done_q       <= done_d;
      bit_q        <= bit_d;
      baud_q       <= baud_d;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end
  assign tx_ready      = !hold_valid_q;
  assign tx_busy       = (state_q != IDLE) || hold_valid_q;
  assign tx_done       = done_q;
  assign tx_serial_out = line_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the 8N1 serial link: accepts bytes from the system-clock domain via a valid/ready handshake and serializes each as start bit, 8 data bits LSB first, and a stop bit on `tx_serial_out`. It is the transmit-side counterpart of the existing receive path and pattern detector. It uses the same `CLK_FREQ`/`BAUD_RATE` parameterization, but derives its bit timing from an internal clock-enable counter rather than a generated clock. A one-byte holding register lets the producer queue the next byte while a frame is on the line, so consecutive frames go out back-to-back.

## Interface
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line bit rate.
- Derived `CLKS_PER_BIT` = `CLK_FREQ / BAUD_RATE`, integer-truncated (217 at defaults). Must be ≥ 2; smaller values are unsupported.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send, sampled on handshake.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_ready`  out  1  holding register empty; byte accepted on any edge where `tx_valid && tx_ready`.
- `tx_serial_out`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  frame in progress or byte held.
- `tx_done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- **Holding register.**
  - `tx_ready` = !`hold_valid`.
  - On handshake, `tx_data` is written into the holding register and `hold_valid` is set.
  - While `hold_valid` is 1, further bytes are refused. `tx_valid` may stay high with no loss or duplication.
- **Data state registers.** Shift register (8 b), bit counter (3 b), baud counter (0..`CLKS_PER_BIT`-1).
  - `bit_end` = (baud counter == `CLKS_PER_BIT`-1).
  - The baud counter clears on every state change.
- **State machine.**
  - **IDLE**: line = 1. If `hold_valid`: load the shift register from the holding register, clear `hold_valid`, clear the bit counter, go to START.
  - **START**: line = 0. On `bit_end` → DATA.
  - **DATA**: line = shift[0].
    - On `bit_end`: shift right.
    - If bit counter == 7 → PARITY (macro defined) or STOP. Otherwise increment the bit counter.
  - **PARITY** (macro only): line = even parity of the sent byte. On `bit_end` → STOP.
  - **STOP**: line = 1. On `bit_end`:
    - Pulse `tx_done`.
    - If `hold_valid`: load the next byte and go directly to START, with no idle cycle.
    - Otherwise → IDLE.
  - Illegal state encoding → IDLE with line = 1.
- **Busy.** `tx_busy` = (state != IDLE) || `hold_valid`.
- **Reset values.** Asserting `reset` immediately (asynchronously) forces:
  - state IDLE, `tx_serial_out` = 1, `hold_valid` = 0, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0.
  - All counters = 0.
  - A partial frame is abandoned. The line returns high mid-bit.

## Timing
- **Acceptance to start bit.** Handshake at edge N → START entered and line low after edge N+1.
- **Bit duration.** Each bit is exactly `CLKS_PER_BIT` cycles.
- **Frame length.** 10 × `CLKS_PER_BIT` cycles, or 11 × with the parity macro.
- **`tx_done`.** High for the single cycle following the edge that ends the stop bit.
- **Back-to-back frames.** Next start bit begins on the same edge that ends the previous stop bit.
  - `tx_ready` rises the cycle after the holding register transfers to the shifter.
  - Earliest refill is therefore one cycle after the transfer.
- **Handshake during the transfer edge.** Not possible: `tx_ready` is 0 while `hold_valid` is 1.
- **Reset release.** First handshake is accepted on the first edge after `reset` deasserts.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state compiled in.
  - One even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit.
  - Frame = 11 bits.
- Undefined:
  - No PARITY state or parity logic.
  - Frame = 10 bits (8N1).

## Test plan
All scenarios use `CLK_FREQ` = 1_000_000 and `BAUD_RATE` = 100_000 (`CLKS_PER_BIT` = 10).

- **Reset.** Assert `reset` low mid-simulation with no clock edge → `tx_serial_out` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0 immediately.
- **Single byte.** Handshake 0x55 at edge N → line low from N+1 for 10 cycles, then bits 1,0,1,0,1,0,1,0, each 10 cycles. Stop high for 10 cycles. `tx_done` pulses 100 cycles after the start bit begins. Line stays high afterwards.
- **Back-to-back.** Send 0xA5, then 0x3C offered continuously.
  - 0x3C is accepted at N+2; `tx_ready` is low until the 0xA5 stop bit ends.
  - 0x3C's start bit directly follows the 0xA5 stop bit, with no idle cycle.
  - Exactly 2 `tx_done` pulses, 100 cycles apart.
- **Reset mid-frame.** Pulse `reset` low during data bit 3 of 0x0F → line high at once, `tx_busy` = 0. A following byte 0xFF transmits as a clean full frame.
- **Flow control.** Hold `tx_valid` high with a changing `tx_data` sequence 0x01..0x04 → exactly 0x01, 0x02, 0x03, 0x04 appear on the line, each once, in order.
- **Parity (`UART_TX_PARITY_EN` defined).** 0x07 → parity bit 1; 0x03 → parity bit 0. Each frame is 110 cycles.
